// File: rtl/blk_62e66b.sv
// Signed divide by 2**shamt truncating toward zero, with matching remainder; 2-stage valid/ready pipe.
// Latency 2 cycles, 1 result/cycle; down_ready low stalls in place and buffers up to 2 requests.
module blk_62e66b #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_quot,
  output logic [N-1:0]  down_rem
);

  logic          s1_valid;
  logic          s2_valid;
  logic [N-1:0]  s1_a;
  logic [N-1:0]  s1_b;
  logic [SW-1:0] s1_s;

  logic          s2_free;
  logic          s1_move;
  logic          up_fire;
  logic [N-1:0]  bias;
  logic [N-1:0]  biased;
  logic [N-1:0]  quot_c;
  logic [N-1:0]  rem_c;

  assign s2_free  = !s2_valid || down_ready;
  assign s1_move  = s1_valid && s2_free;
  assign up_ready = !s1_valid || s1_move;
  assign up_fire  = up_valid && up_ready;

  // Negative dividends get 2**s-1 added so the floor shift lands on the truncated quotient.
  assign bias   = up_data[N-1] ? ~({N{1'b1}} << up_shamt) : '0;
  assign biased = up_data + bias;

  assign quot_c = N'({{N{s1_b[N-1]}}, s1_b} >> s1_s);
  assign rem_c  = s1_a - (quot_c << s1_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_s     <= '0;
    end else begin
      if (up_ready) s1_valid <= up_valid;
      if (up_fire) begin
        s1_a <= up_data;
        s1_b <= biased;
        s1_s <= up_shamt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      down_quot <= '0;
      down_rem  <= '0;
    end else begin
      if (s2_free) s2_valid <= s1_valid;
      if (s1_move) begin
        down_quot <= quot_c;
        down_rem  <= rem_c;
      end
    end
  end

  assign down_valid = s2_valid;

endmodule

// File: tb/tb_blk_62e66b.sv
// Scoreboard bench for blk_62e66b: driver pushes model results, negedge monitor pops and compares.
module tb_blk_62e66b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [7:0] up_data = '0;
  logic [2:0] up_shamt = '0;
  logic       down_valid;
  logic       down_ready = 1'b0;
  logic [7:0] down_quot;
  logic [7:0] down_rem;

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic [7:0] q;
    logic [7:0] r;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   check_lat = 0;
  bit   rnd_ready = 0;
  bit   force_ready = 0;

  blk_62e66b #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_shamt(up_shamt),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_quot(down_quot), .down_rem(down_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    down_ready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  function automatic exp_t model(input logic [7:0] a, input logic [2:0] s);
    exp_t e;
    int ai, d;
    ai  = int'($signed(a));
    d   = 1 << s;
    e.a = a;
    e.s = s;
    e.q = 8'(ai / d);
    e.r = 8'(ai % d);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: values at negedge are what the next rising edge will see.
  bit         prev_stall = 0;
  logic [7:0] prev_q, prev_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", {15'd0, down_valid}, 16'd1);
        chk("stall_hold_data", {down_quot, down_rem}, {prev_q, prev_r});
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {down_quot, down_rem}, 16'hxxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("result a=%0d s=%0d", $signed(e.a), e.s), {down_quot, down_rem}, {e.q, e.r});
          if (check_lat) chk("latency", 16'(cyc - e.cyc), 16'd2);
        end
      end
      prev_stall = down_valid && !down_ready;
      prev_q = down_quot;
      prev_r = down_rem;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is accepted.
  task automatic send(input logic [7:0] a, input logic [2:0] s);
    exp_t e;
    up_data  = a;
    up_shamt = s;
    up_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (up_ready) begin
        e = model(a, s);
        e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 16'd0, 16'd1);
    up_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_down_valid", {15'd0, down_valid}, 16'd0);
    chk("rst_up_ready", {15'd0, up_ready}, 16'd1);
    chk("rst_outputs", {down_quot, down_rem}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_ready = 1;
    @(posedge clk);
    #1;

    // Single request latency and directed boundaries
    check_lat = 1;
    send(8'hF9, 3'd1);
    drain();
    send(8'h80, 3'd7);
    send(8'h80, 3'd0);
    send(8'h7F, 3'd3);
    send(8'hFF, 3'd5);
    send(8'hFF, 3'd1);
    send(8'h55, 3'd0);
    drain();

    // Back-to-back stream: latency 2 on every item means consecutive output cycles
    for (int i = 0; i < 10; i++) send(8'($urandom), 3'($urandom_range(0, 7)));
    drain();
    check_lat = 0;

    // Backpressure fills both stages
    force_ready = 0;
    @(posedge clk);
    #1;
    send(8'hC3, 3'd2);
    send(8'h3C, 3'd4);
    @(negedge clk);
    chk("full_up_ready", {15'd0, up_ready}, 16'd0);
    chk("full_down_valid", {15'd0, down_valid}, 16'd1);
    repeat (4) @(posedge clk);
    #1;
    force_ready = 1;
    drain();

    // Async reset with two requests in flight
    force_ready = 0;
    @(posedge clk);
    #1;
    send(8'h91, 3'd3);
    send(8'h6E, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_down_valid", {15'd0, down_valid}, 16'd0);
    chk("async_rst_up_ready", {15'd0, up_ready}, 16'd1);
    exp_q.delete();
    force_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_up_ready", {15'd0, up_ready}, 16'd1);
    chk("post_rst_down_valid", {15'd0, down_valid}, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    send(8'hEC, 3'd2);
    drain();

    // Random traffic with random downstream readiness
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), 3'($urandom_range(0, 7)));
    end
    rnd_ready = 0;
    force_ready = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
